// File: rtl/series_coef_reader.sv
// series_coef_reader
// Walks the coefficient LUT and accumulates sum(coef[i] * x^i), i = 0 .. N_TERMS-1,
// in unsigned fixed point with FRAC_BITS fractional bits.
// Optional feature macro: SERIES_EARLY_TERM_EN -- finish as soon as the running
// power of x collapses to zero, since every later term would contribute 0.
module series_coef_reader #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ADDR_W    = 4,
    parameter int N_TERMS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_x_in,
    output logic [ADDR_W-1:0]   o_lut_addr,
    input  logic [DATA_W-1:0]   i_lut_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_W+2:0]   o_result
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int WIDE_W = PROD_W - FRAC_BITS;
    localparam int ACC_W  = DATA_W + 3;
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1 << FRAC_BITS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_x;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_lut_addr;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_pow;
    logic [ACC_W-1:0]    r_result;

    logic [PROD_W-1:0]   w_term_prod;
    logic [WIDE_W-1:0]   w_term_wide;
    logic [DATA_W-1:0]   w_term;
    logic [PROD_W-1:0]   w_pow_prod;
    logic [WIDE_W-1:0]   w_pow_wide;
    logic [DATA_W-1:0]   w_pow_next;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;
    logic                w_exit;

    // Per-term arithmetic: rescale both products back to FRAC_BITS and clamp to DATA_W.
    assign w_term_prod = PROD_W'(i_lut_data) * PROD_W'(r_pow);
    assign w_term_wide = w_term_prod[PROD_W-1:FRAC_BITS];
    assign w_term      = (|w_term_wide[WIDE_W-1:DATA_W]) ? '1 : w_term_wide[DATA_W-1:0];

    assign w_pow_prod  = PROD_W'(r_pow) * PROD_W'(r_x);
    assign w_pow_wide  = w_pow_prod[PROD_W-1:FRAC_BITS];
    assign w_pow_next  = (|w_pow_wide[WIDE_W-1:DATA_W]) ? '1 : w_pow_wide[DATA_W-1:0];

    assign w_sum  = r_acc + ACC_W'(w_term);
    assign w_last = (r_idx == LAST_IDX);

`ifdef SERIES_EARLY_TERM_EN
    assign w_exit = w_last || (w_pow_next == '0);
`else
    assign w_exit = w_last;
`endif

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_lut_addr = r_lut_addr;
    assign o_result   = r_result;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_exit)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch x on start, accumulate one term per RUN cycle, capture result on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_idx      <= '0;
            r_lut_addr <= '0;
            r_acc      <= '0;
            r_pow      <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x        <= i_x_in;
                        r_idx      <= '0;
                        r_lut_addr <= '0;
                        r_acc      <= '0;
                        r_pow      <= ONE;
                    end
                end
                S_RUN: begin
                    r_acc      <= w_sum;
                    r_pow      <= w_pow_next;
                    r_idx      <= r_idx + ADDR_W'(1);
                    r_lut_addr <= r_idx + ADDR_W'(1);
                    if (w_exit) begin
                        r_result <= w_sum;
                    end
                end
                S_DONE: begin
                    r_idx      <= '0;
                    r_lut_addr <= '0;
                end
                default: begin
                    r_idx      <= '0;
                    r_lut_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_coef_reader.sv
// Bench for series_coef_reader: directed table/x cases plus randomized tables and
// arguments, checked against a plain-arithmetic series model.
// Honours SERIES_EARLY_TERM_EN when computing the expected latency.
module tb_series_coef_reader;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ADDR_W    = 4;
    localparam int N_TERMS   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_start = 1'b0;
    logic [DATA_W-1:0]   i_x_in = '0;
    logic [ADDR_W-1:0]   o_lut_addr;
    logic [DATA_W-1:0]   i_lut_data;
    logic                o_busy;
    logic                o_done;
    logic [DATA_W+2:0]   o_result;

    logic [DATA_W-1:0]   lut_mem [16];
    logic [31:0]         exp_prev = 32'd0;
    int                  checks = 0;
    int                  failures = 0;

    series_coef_reader #(
        .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ADDR_W(ADDR_W), .N_TERMS(N_TERMS)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_x_in(i_x_in),
        .o_lut_addr(o_lut_addr), .i_lut_data(i_lut_data),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    always #5 clk = ~clk;

    // Combinational LUT model.
    assign i_lut_data = lut_mem[o_lut_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the series term by term; edges = RUN cycles needed.
    function automatic void model(input logic [15:0] x, output logic [31:0] res, output int edges);
        longint unsigned acc, pw, t;
        acc = 0;
        pw  = 256;
        edges = 0;
        for (int i = 0; i < N_TERMS; i++) begin
            t = (longint'(lut_mem[i]) * pw) / 256;
            if (t > 65535) t = 65535;
            acc += t;
            pw = (pw * longint'(x)) / 256;
            if (pw > 65535) pw = 65535;
            edges = i + 1;
`ifdef SERIES_EARLY_TERM_EN
            if (pw == 0) break;
`endif
        end
        res = 32'(acc);
    endfunction

    // One evaluation, entered at a negedge with the DUT idle; returns at the idle
    // negedge following DONE so the next call starts in the first IDLE cycle.
    task automatic run_eval(input logic [15:0] x, input bit inject, input string name);
        logic [31:0] exp_res;
        int exp_edges, cyc, busy_cnt;
        bit done_seen;
        model(x, exp_res, exp_edges);
        i_start = 1'b1;
        i_x_in  = x;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_x_in  = 16'($urandom);
        cyc = 0;
        busy_cnt = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_seen = 1'b1;
            end else begin
                check({name, " lut_addr"}, 32'(o_lut_addr), 32'(cyc - 1));
                check({name, " result_hold"}, 32'(o_result), exp_prev);
                if (inject && cyc == 3) begin
                    i_start = 1'b1;
                    i_x_in  = x ^ 16'h0300;
                end
            end
        end
        check({name, " done_seen"}, 32'(done_seen), 32'd1);
        check({name, " latency"}, 32'(cyc - 1), 32'(exp_edges));
        check({name, " result"}, 32'(o_result), exp_res);
        @(negedge clk);
        if (o_busy) busy_cnt++;
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_edges + 1));
        check({name, " idle_done"}, 32'(o_done), 32'd0);
        check({name, " idle_addr"}, 32'(o_lut_addr), 32'd0);
        check({name, " idle_result"}, 32'(o_result), exp_res);
        exp_prev = exp_res;
        $display("eval %s x=0x%04h result=0x%05h exp=0x%05h edges=%0d", name, x, o_result, exp_res, cyc - 1);
    endtask

    initial begin
        logic [15:0] tbl [8];
        int no_done;
        tbl = '{16'h0080, 16'h0015, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0001};
        for (int i = 0; i < 16; i++) lut_mem[i] = (i < 8) ? tbl[i] : 16'($urandom);

        // Reset state.
        #1;
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check("rst addr", 32'(o_lut_addr), 32'd0);
        check("rst result", 32'(o_result), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, chained back to back.
        run_eval(16'h0100, 1'b0, "x1.0");
        check("x1.0 value", exp_prev, 32'h00A6);
        run_eval(16'h0200, 1'b0, "x2.0");
        check("x2.0 value", exp_prev, 32'h01EA);
        run_eval(16'h1000, 1'b0, "x16.0");
        check("x16.0 value", exp_prev, 32'h12CA);
        run_eval(16'h0000, 1'b0, "x0");
        check("x0 value", exp_prev, 32'h0080);
        run_eval(16'h0180, 1'b1, "ignore_start");

        // Reset in the middle of RUN.
        @(negedge clk);
        i_start = 1'b1;
        i_x_in  = 16'h0100;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst done", 32'(o_done), 32'd0);
        check("midrst addr", 32'(o_lut_addr), 32'd0);
        check("midrst result", 32'(o_result), 32'd0);
        exp_prev = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        no_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_done || o_busy) no_done++;
        end
        check("midrst no_activity", 32'(no_done), 32'd0);
        $display("eval midrst aborted busy_after=%0d", no_done);

        // Randomized tables and arguments.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 16; i++)
                lut_mem[i] = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
            case (r % 4)
                0: i_x_in = 16'($urandom);
                1: i_x_in = 16'($urandom_range(0, 16'h0080));
                default: i_x_in = 16'($urandom_range(0, 16'h0300));
            endcase
            run_eval(i_x_in, r[0], $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/series_coef_reader.md
Name: series_coef_reader

Overview:
- Sequencer that reads the 16-entry coefficient look-up table and evaluates the polynomial series sum(coef[i] * x^i) for i = 0 .. N_TERMS-1.
- Drives the table's 4-bit address and consumes its 16-bit combinational data output.
- Sits between the control unit, which supplies start/x and waits for done, and the coefficient LUT.

Parameters:
- DATA_W, 16: width of x, coefficients, power register and per-term value.
- FRAC_BITS, 8: fractional bits of the unsigned fixed-point format; 1.0 = 1 << FRAC_BITS.
- ADDR_W, 4: LUT address width.
- N_TERMS, 8: number of series terms; must satisfy 1 <= N_TERMS <= 2^ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an evaluation; sampled only in IDLE.
- x_in  in  DATA_W  unsigned fixed-point argument; latched on accepted start.
- lut_addr  out  ADDR_W  coefficient address to the LUT.
- lut_data  in  DATA_W  coefficient from the LUT; combinational, valid in the same cycle as lut_addr.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  DATA_W+3  series sum; held until the next accepted start.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0: lut_addr=0, busy=0, done=0, result=0.
  - Internal state: state=IDLE, idx=0, acc=0, pow=0, x_reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, with start=1 at an edge:
  - Go to RUN.
  - x_reg <= x_in, idx <= 0, lut_addr <= 0, acc <= 0, pow <= 1<<FRAC_BITS.
  - busy=1 from the next cycle.
- RUN, each edge processes term idx:
  - term = (lut_data * pow) >> FRAC_BITS, saturated to 2^DATA_W-1.
  - acc <= acc + term. acc is DATA_W+3 bits and cannot overflow for N_TERMS <= 8.
  - pow <= (pow * x_reg) >> FRAC_BITS, saturated to 2^DATA_W-1.
  - idx <= idx+1 and lut_addr <= idx+1.
- RUN exit: when idx == N_TERMS-1, the same edge goes to DONE, registers result <= acc+term, and sets done=1.
- DONE: lasts exactly one cycle; the next edge returns to IDLE with done=0, busy=0 and lut_addr=0.
- Latency: the start edge is E0. Done is high in the cycle after edge E(N_TERMS), i.e. 8 cycles after the start edge at default settings.
- start is ignored while in RUN or DONE; no queuing.
- x_in changes after acceptance have no effect.
- result changes only at the RUN->DONE edge or on reset.
- Reset mid-RUN aborts the evaluation immediately; no done pulse is produced.

Optional Feature:
- Macro: SERIES_EARLY_TERM_EN.
- When defined, in RUN: if the updated pow is zero, that same edge goes to DONE with result <= acc+term. All remaining terms would contribute 0, so the result is identical and done arrives earlier.
- When not defined, every evaluation always takes exactly N_TERMS RUN cycles.

Test Plan:
- Load LUT coefficients 0x0080, 0x0015, 0x0008, 0x0004, 0x0002, 0x0001, 0x0001, 0x0001 (entries 0-7). Set x_in=0x0100 (1.0) and pulse start -> lut_addr steps 0..7 on consecutive cycles; done=1 exactly 8 cycles after the start edge; result=0x00A6.
- Same table, x_in=0x0200 (2.0) -> result=0x01EA; busy high for 9 cycles (8 RUN + 1 DONE).
- Same table, x_in=0x1000 (16.0): pow saturates to 0xFFFF from term 2 onward -> result=0x12CA.
- Same table, x_in=0x0000 -> result=0x0080.
  - With SERIES_EARLY_TERM_EN: done 1 cycle after the start edge.
  - Without it: done 8 cycles after the start edge.
- Pulse start again on cycle 3 of RUN with a different x_in -> ignored; result still matches the first x_in. Then assert rst during RUN -> busy, done, result and lut_addr go to 0 asynchronously; no done pulse follows.
- Two back-to-back evaluations, with start asserted in the first IDLE cycle after DONE -> both accepted; second result is correct; the first result holds until the second done.
